imm_gen_stage: RTL and testbench

// - Pipelined, parametrised immediate generator. Sits between the instruction register and execute.
// - Decodes U/I/S/B/J/Z immediates to XLEN bits, sign- or zero-extending as the format requires.
// - Registers the result with valid/ready handshakes and a 2-entry skid buffer, so it sustains full throughput.
// - Flags illegal selects and keeps a saturating count of them.

---
 rtl/imm_gen_if.sv | 45 ++++
 rtl/imm_gen_stage.sv | 142 ++++++++++++++
 tb/tb_imm_gen_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_if.sv
// Handshake bundle between the instruction register, immediate generator and execute.
// Ports: in_* request side (valid/ready, ir, select, tag), out_* result side (valid/ready, data, tag, illegal).
interface imm_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction_register;
    logic [3:0]       immediate_select;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immediate_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    // Stage side: consumes requests, produces results.
    modport slave (
        input  in_valid,
        output in_ready,
        input  instruction_register,
        input  immediate_select,
        input  in_tag,
        output out_valid,
        input  out_ready,
        output immediate_data,
        output out_tag,
        output out_illegal
    );

    // Environment side: drives requests, accepts results.
    modport master (
        output in_valid,
        input  in_ready,
        output instruction_register,
        output immediate_select,
        output in_tag,
        input  out_valid,
        output out_ready,
        input  immediate_data,
        input  out_tag,
        input  out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: U/I/S/B/J/Z decode (plus RVC CI/CJ/CB/CIW when
// IMM_GEN_RVC_EN is defined) into a 2-entry head+skid buffer with registered in_ready.
// Ports: clk, rst_n (async, active-low), bus (imm_gen_if.slave), illegal_count (saturating).
// XLEN must be 32 or 64.
module imm_gen_stage #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imm_gen_if.slave             bus,
    output logic [ILL_CNT_W-1:0] illegal_count
);

    typedef struct packed {
        logic             ill;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } entry_t;

    logic [31:0]     ir;
    logic [15:0]     c;
    logic [XLEN-1:0] imm;
    logic            ill;
    entry_t          new_e;

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_v_q, head_v_d;
    logic   skid_v_q, skid_v_d;
    logic   rdy_q, rdy_d;
    logic   [ILL_CNT_W-1:0] cnt_q, cnt_d;

    logic push;
    logic pop;

    assign ir = bus.instruction_register;
    assign c  = ir[15:0];

    // Format decode; XLEN'($signed(x)) sign-extends the assembled field.
    always_comb begin
        imm = '0;
        ill = 1'b0;
        unique case (bus.immediate_select)
            4'b0000: imm = XLEN'($signed({ir[31:12], 12'b0}));
            4'b0001: imm = XLEN'($signed(ir[31:20]));
            4'b0010: imm = XLEN'($signed({ir[31:25], ir[11:7]}));
            4'b0011: imm = XLEN'($signed({ir[31], ir[7],
                                          ir[30:25], ir[11:8],
                                          1'b0}));
            4'b0100: imm = XLEN'($signed({ir[31], ir[19:12],
                                          ir[20], ir[30:21],
                                          1'b0}));
            4'b0101: imm = XLEN'(ir[19:15]);
`ifdef IMM_GEN_RVC_EN
            4'b1000: imm = XLEN'($signed({c[12], c[6:2]}));
            4'b1001: imm = XLEN'($signed({c[12], c[8], c[10:9],
                                          c[6], c[7], c[2],
                                          c[11], c[5:3], 1'b0}));
            4'b1010: imm = XLEN'($signed({c[12], c[6:5], c[2],
                                          c[11:10], c[4:3],
                                          1'b0}));
            4'b1011: imm = XLEN'({c[10:7], c[12:11], c[5],
                                  c[6], 2'b00});
`endif
            default: ill = 1'b1;
        endcase
    end

`ifdef IMM_GEN_RVC_EN
    logic unused_ir;
    assign unused_ir = ^ir[1:0];
`else
    logic unused_ir;
    assign unused_ir = ^{ir[6:0], c[15:0]};
`endif

    assign new_e.ill  = ill;
    assign new_e.tag  = bus.in_tag;
    assign new_e.data = ill ? '0 : imm;

    assign push = bus.in_valid & rdy_q;
    assign pop  = head_v_q & bus.out_ready;

    // Head refills from skid first (FIFO order), else from the input.
    // The skid only fills while the head is held.
    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        cnt_d    = cnt_q;
        if (!head_v_q || pop) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                head_v_d = 1'b1;
                skid_v_d = push;
                if (push) skid_d = new_e;
            end else if (push) begin
                head_d   = new_e;
                head_v_d = 1'b1;
            end else begin
                head_v_d = 1'b0;
            end
        end else if (push) begin
            skid_d   = new_e;
            skid_v_d = 1'b1;
        end
        if (push && ill && (cnt_q != '1)) begin
            cnt_d = cnt_q + ILL_CNT_W'(1);
        end
        // Registered so in_ready has no path from out_ready.
        rdy_d = !(head_v_d && skid_v_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b1;
            cnt_q    <= '0;
        end else begin
            head_q   <= head_d;
            skid_q   <= skid_d;
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready       = rdy_q;
    assign bus.out_valid      = head_v_q;
    assign bus.immediate_data = head_q.data;
    assign bus.out_tag        = head_q.tag;
    assign bus.out_illegal    = head_q.ill;
    assign illegal_count      = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed + random bench for imm_gen_stage: a 32-bit/8-bit-count instance and a
// 64-bit/2-bit-count instance share one stimulus stream and one queue model.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imm_gen_if #(.XLEN(32), .TAG_W(32)) bus ();
    imm_gen_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    logic [7:0] cnt32;
    logic [1:0] cnt64;

    assign bus64.in_valid             = bus.in_valid;
    assign bus64.instruction_register = bus.instruction_register;
    assign bus64.immediate_select     = bus.immediate_select;
    assign bus64.in_tag               = bus.in_tag;
    assign bus64.out_ready            = bus.out_ready;

    imm_gen_stage #(.XLEN(32), .TAG_W(32), .ILL_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .illegal_count(cnt32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32), .ILL_CNT_W(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(bus64), .illegal_count(cnt64)
    );

    typedef struct {
        logic [63:0] data;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   m_cnt;
    int   n_vec = 0;
    int   n_err = 0;

    // Immediate value from the field layout, using plain integer weights.
    function automatic longint ref_imm(input logic [3:0] s,
                                       input logic [31:0] ir,
                                       output bit ill);
        longint b31;
        logic [15:0] c;
        longint c12;
        b31 = longint'(ir[31]);
        c   = ir[15:0];
        c12 = longint'(c[12]);
        ill = 1'b0;
        case (s)
            4'd0: return longint'(ir[31:12]) * 4096 - b31 * 64'h1_0000_0000;
            4'd1: return longint'(ir[31:20]) - b31 * 4096;
            4'd2: return longint'({ir[31:25], ir[11:7]}) - b31 * 4096;
            4'd3: return b31 * 4096 + longint'(ir[7]) * 2048
                       + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2
                       - b31 * 8192;
            4'd4: return b31 * 1048576 + longint'(ir[19:12]) * 4096
                       + longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2
                       - b31 * 2097152;
            4'd5: return longint'(ir[19:15]);
`ifdef IMM_GEN_RVC_EN
            4'd8: return c12 * 32 + longint'(c[6:2]) - c12 * 64;
            4'd9: return c12 * 2048 + longint'(c[8]) * 1024
                       + longint'(c[10:9]) * 256 + longint'(c[6]) * 128
                       + longint'(c[7]) * 64 + longint'(c[2]) * 32
                       + longint'(c[11]) * 16 + longint'(c[5:3]) * 2
                       - c12 * 4096;
            4'd10: return c12 * 256 + longint'(c[6:5]) * 64
                        + longint'(c[2]) * 32 + longint'(c[11:10]) * 8
                        + longint'(c[4:3]) * 2 - c12 * 512;
            4'd11: return longint'(c[10:7]) * 64 + longint'(c[12:11]) * 16
                        + longint'(c[5]) * 8 + longint'(c[6]) * 4;
`endif
            default: begin
                ill = 1'b1;
                return 0;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("in_ready32", 64'(bus.in_ready), 64'(sz < 2));
        chk("in_ready64", 64'(bus64.in_ready), 64'(sz < 2));
        chk("out_valid32", 64'(bus.out_valid), 64'(sz > 0));
        chk("out_valid64", 64'(bus64.out_valid), 64'(sz > 0));
        if (sz > 0) begin
            chk("data32", 64'(bus.immediate_data), 64'(q[0].data[31:0]));
            chk("data64", bus64.immediate_data, q[0].data);
            chk("tag32", 64'(bus.out_tag), 64'(q[0].tag));
            chk("tag64", 64'(bus64.out_tag), 64'(q[0].tag));
            chk("ill32", 64'(bus.out_illegal), 64'(q[0].ill));
            chk("ill64", 64'(bus64.out_illegal), 64'(q[0].ill));
        end
        chk("cnt32", 64'(cnt32), 64'((m_cnt > 255) ? 255 : m_cnt));
        chk("cnt64", 64'(cnt64), 64'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    // One clock: model accepts when it holds fewer than 2 entries.
    task automatic step();
        bit   acc;
        bit   pp;
        bit   il;
        exp_t e;
        acc = bus.in_valid && (q.size() < 2);
        pp  = (q.size() > 0) && bus.out_ready;
        e.data = 64'(ref_imm(bus.immediate_select,
                             bus.instruction_register, il));
        e.tag  = bus.in_tag;
        e.ill  = il;
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            if (il) m_cnt++;
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [3:0] s,
                         input logic [31:0] ir, input logic [31:0] tag);
        bus.in_valid             = v;
        bus.immediate_select     = s;
        bus.instruction_register = ir;
        bus.in_tag               = tag;
    endtask

    initial begin
        m_cnt = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", bus64.immediate_data, 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_ill", 64'(bus.out_illegal), 64'd0);
        chk("rst_cnt", 64'(cnt32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_ready", 64'(bus.in_ready), 64'd1);

        drive(1'b1, 4'd1, 32'hFFF0_0093, 32'd1);
        step();
        chk("I_fixed", 64'(bus.immediate_data), 64'hFFFF_FFFF);
        drive(1'b1, 4'd3, 32'h8000_0063, 32'd2);
        step();
        chk("B_fixed", bus64.immediate_data, 64'hFFFF_FFFF_FFFF_F000);
        drive(1'b1, 4'd4, 32'h0010_006F, 32'd3);
        step();
        chk("J_fixed", bus64.immediate_data, 64'h800);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();

        bus.out_ready = 1'b0;
        drive(1'b1, 4'd5, 32'h000F_8000, 32'd1);
        step();
        drive(1'b1, 4'd2, 32'hFE00_0F80, 32'd2);
        step();
        chk("full_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 4'd0, 32'h1234_5000, 32'd3);
        step();
        chk("stall_tag", 64'(bus.out_tag), 64'd1);
        bus.out_ready = 1'b1;
        step();
        chk("order2", 64'(bus.out_tag), 64'd2);
        step();
        chk("order3", 64'(bus.out_tag), 64'd3);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        step();

        drive(1'b1, 4'b0110, 32'hFFFF_FFFF, 32'd5);
        step();
        drive(1'b1, 4'b0111, 32'hFFFF_FFFF, 32'd5);
        step();
        chk("ill_flag", 64'(bus.out_illegal), 64'd1);
        chk("ill_data", 64'(bus.immediate_data), 64'd0);
        chk("ill_cnt2", 64'(cnt32), 64'd2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b1100 | 4'(i & 3), 32'hFFFF_FFFF, 32'(i));
            step();
        end
        chk("sat_cnt", 64'(cnt64), 64'd3);
        chk("cnt7", 64'(cnt32), 64'd7);

        drive(1'b1, 4'b1000, 32'h0000_1FFD, 32'd9);
        step();
`ifdef IMM_GEN_RVC_EN
        chk("CI_fixed", 64'(bus.immediate_data), 64'hFFFF_FFFF);
`else
        chk("CI_ill", 64'(bus.out_illegal), 64'd1);
        chk("CI_zero", 64'(bus.immediate_data), 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 4'($urandom_range(0, 15)),
                  $urandom, $urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        bus.out_ready = 1'b0;
        drive(1'b1, 4'd1, 32'h7FF0_0000, 32'd11);
        step();
        drive(1'b1, 4'd7, 32'h0, 32'd12);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_cnt = 0;
        chk("mid_valid32", 64'(bus.out_valid), 64'd0);
        chk("mid_valid64", 64'(bus64.out_valid), 64'd0);
        chk("mid_cnt32", 64'(cnt32), 64'd0);
        chk("mid_cnt64", 64'(cnt64), 64'd0);
        chk("mid_tag", 64'(bus.out_tag), 64'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("post_ready", 64'(bus.in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
